// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Purpose  : RV32I instruction fetch stage. Issues word fetches for the
//            current PC over a valid/ready request port, tracks in-flight
//            requests, buffers returned instructions with their PCs for
//            decode and computes the next PC for the program counter.
//            Branch/jump redirects flush the buffer and discard the
//            responses of requests that were already in flight.
// Ports    : clk, rst (sync, active-low)
//            pc / pc_next               - program counter register loop
//            redirect_valid/target      - taken branch/jump
//            imem_req_valid/ready/addr  - fetch request port
//            imem_rsp_valid/data        - in-order fetch response port
//            if_valid/ready/instr/pc    - instruction stream toward decode
// Params   : DEPTH - instruction buffer and address queue entries
//                    (power of two, >= 2)
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] pc_next,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc
);

  // Pointer width and counter width (counters must hold the value DEPTH).
  localparam int c_AW = $clog2(DEPTH);
  localparam int c_CW = c_AW + 1;
  localparam logic [c_CW:0] c_DEPTH = (c_CW + 1)'(DEPTH);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [c_CW-1:0] r_out_cnt;    // accepted requests not yet answered
  logic [c_CW-1:0] r_drop_cnt;   // in-flight responses to throw away
  logic [c_CW-1:0] r_occ;        // instruction buffer occupancy

  logic [31:0]     r_aq_mem [DEPTH];
  logic [c_AW-1:0] r_aq_wr;
  logic [c_AW-1:0] r_aq_rd;

  logic [31:0]     r_buf_pc    [DEPTH];
  logic [31:0]     r_buf_instr [DEPTH];
  logic [c_AW-1:0] r_buf_wr;
  logic [c_AW-1:0] r_buf_rd;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [31:0]   w_aligned_pc;
  logic          w_pop;
  logic          w_deq;
  logic [c_CW:0] w_committed;
  logic          w_credit;
  logic          w_req_valid;
  logic          w_accept;
  logic          w_push;
  logic          w_drop_rsp;
  logic          w_unused_tgt;

  assign w_aligned_pc = {pc[31:2], 2'b00};
  assign w_unused_tgt = ^redirect_target[1:0];

  // Raw pop feeds the credit check; a redirect cancels the actual dequeue
  // because the whole buffer is flushed that cycle anyway.
  assign w_pop = if_valid & if_ready;
  assign w_deq = w_pop & ~redirect_valid;

  // Slots already spoken for: every in-flight request will land in the
  // buffer (or be dropped), so a new request is only allowed while the
  // sum of in-flight and buffered entries leaves room for it.
  assign w_committed = {1'b0, r_out_cnt} + {1'b0, r_occ} - (c_CW + 1)'(w_pop);
  assign w_credit    = (w_committed < c_DEPTH);

  assign w_req_valid = rst & ~redirect_valid & w_credit;
  assign w_accept    = w_req_valid & imem_req_ready;

  // A response landing in the redirect cycle belongs to the old path.
  assign w_drop_rsp  = imem_rsp_valid & (r_drop_cnt != '0);
  assign w_push      = imem_rsp_valid & (r_drop_cnt == '0) & ~redirect_valid;

  always_comb begin
    pc_next = pc;
    if (rst) begin
      if (redirect_valid) begin
        pc_next = {redirect_target[31:2], 2'b00};
      end else if (w_accept) begin
        pc_next = pc + 32'd4;
      end
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = w_aligned_pc;

  assign if_valid = (r_occ != '0);
  assign if_instr = r_buf_instr[r_buf_rd];
  assign if_pc    = r_buf_pc[r_buf_rd];

  // --------------------------------------------------------------------------
  // In-flight tracking: outstanding count, drop count, address queue
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_out_cnt  <= '0;
      r_drop_cnt <= '0;
      r_aq_wr    <= '0;
      r_aq_rd    <= '0;
    end else begin
      r_out_cnt <= r_out_cnt + c_CW'(w_accept) - c_CW'(imem_rsp_valid);

      if (w_accept) begin
        r_aq_wr <= r_aq_wr + c_AW'(1);
      end
      // Dropped responses still consume their queue entry so that later
      // responses stay paired with the right PC.
      if (imem_rsp_valid) begin
        r_aq_rd <= r_aq_rd + c_AW'(1);
      end

      // No request is issued in a redirect cycle, so everything still
      // outstanding after this cycle's response is from the old path.
      if (redirect_valid) begin
        r_drop_cnt <= r_out_cnt - c_CW'(imem_rsp_valid);
      end else if (w_drop_rsp) begin
        r_drop_cnt <= r_drop_cnt - c_CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_aq_mem[r_aq_wr] <= w_aligned_pc;
    end
  end

  // --------------------------------------------------------------------------
  // Instruction buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_occ    <= '0;
      r_buf_wr <= '0;
      r_buf_rd <= '0;
    end else if (redirect_valid) begin
      r_occ    <= '0;
      r_buf_wr <= '0;
      r_buf_rd <= '0;
    end else begin
      r_occ <= r_occ + c_CW'(w_push) - c_CW'(w_deq);
      if (w_push) begin
        r_buf_wr <= r_buf_wr + c_AW'(1);
      end
      if (w_deq) begin
        r_buf_rd <= r_buf_rd + c_AW'(1);
      end
    end
  end

  // Payload storage needs no reset: entries are only read while valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_buf_wr]    <= r_aq_mem[r_aq_rd];
      r_buf_instr[r_buf_wr] <= imem_rsp_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fetch_unit
// Purpose  : Self-checking bench for fetch_unit. A behavioural memory with
//            random latency answers requests in order; a queue-based model
//            of the expected decode stream and next-PC rules checks the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc = 32'h0;
  logic [31:0] pc_next;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc             (pc),
    .pc_next        (pc_next),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } req_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } ent_t;

  req_t mq[$];   // requests accepted by memory, oldest first
  ent_t eb[$];   // instructions decode is expected to see, oldest first

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Stimulus knobs (percent probabilities)
  int p_rdy   = 100;
  int p_ifr   = 100;
  int p_rsp   = 100;
  int p_redir = 0;
  int max_lat = 1;
  bit force_redir = 1'b0;
  logic [31:0] redir_tgt = 32'h0;
  bit last_acc = 1'b0;

  function automatic logic [31:0] memword(logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0000_0013;
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check against the model, advance model,
  // clock edge, then load the PC register from pc_next.
  task automatic tick();
    bit          pop;
    bit          ereq;
    logic [31:0] epn;
    logic [31:0] pn_seen;
    req_t        r;
    int          inflight;

    imem_req_ready  = ($urandom_range(99) < p_rdy);
    if_ready        = ($urandom_range(99) < p_ifr);
    redirect_valid  = rst && (force_redir || ($urandom_range(99) < p_redir));
    redirect_target = force_redir ? redir_tgt : $urandom;
    imem_rsp_valid  = rst && (mq.size() > 0) && (mq.size() > 0 ? mq[0].due <= cyc : 1'b0)
                      && ($urandom_range(99) < p_rsp);
    imem_rsp_data   = imem_rsp_valid ? memword(mq[0].addr) : $urandom;
    #1;

    pop      = (eb.size() > 0) && if_ready;
    inflight = mq.size() + eb.size() - (pop ? 1 : 0);
    ereq     = rst && !redirect_valid && (inflight < DEPTH);

    chk("if_valid", {31'b0, if_valid}, {31'b0, eb.size() > 0});
    if (eb.size() > 0) begin
      chk("if_pc", if_pc, eb[0].pc);
      chk("if_instr", if_instr, eb[0].ins);
    end
    chk("req_valid", {31'b0, imem_req_valid}, {31'b0, ereq});
    if (rst) chk("req_addr", imem_req_addr, pc & 32'hFFFF_FFFC);

    last_acc = ereq && imem_req_ready;
    if (!rst)                epn = pc;
    else if (redirect_valid) epn = redirect_target & 32'hFFFF_FFFC;
    else if (last_acc)       epn = pc + 32'd4;
    else                     epn = pc;
    chk("pc_next", pc_next, epn);
    pn_seen = pc_next;

    if (!rst) begin
      mq.delete();
      eb.delete();
    end else begin
      if (!redirect_valid && pop) void'(eb.pop_front());
      if (imem_rsp_valid) begin
        r = mq.pop_front();
        if (!r.stale && !redirect_valid) eb.push_back('{r.addr, imem_rsp_data});
      end
      if (redirect_valid) begin
        eb.delete();
        foreach (mq[i]) mq[i].stale = 1'b1;
      end
      if (last_acc) mq.push_back('{pc & 32'hFFFF_FFFC, cyc + $urandom_range(max_lat, 1), 1'b0});
    end

    @(posedge clk);
    #1;
    pc = pn_seen;
    cyc++;
  endtask

  initial begin
    bit seen;

    // Initial reset without checks: registers are unknown until the first edge.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset cycles with checks.
    repeat (2) tick();

    // Boot: 1-cycle memory, decode always ready.
    rst = 1'b1; p_rdy = 100; p_ifr = 100; p_rsp = 100; max_lat = 1;
    tick();
    tick();
    chk("boot_if_valid", {31'b0, if_valid}, 32'd1);
    chk("boot_if_pc", if_pc, 32'h0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("thru_if_valid", {31'b0, if_valid}, 32'd1);
      chk("thru_if_pc", if_pc, 32'd4 * (k + 1));
    end

    // Decode stall for 5 cycles, then release.
    p_ifr = 0;
    repeat (5) tick();
    chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd0);
    p_ifr = 100;
    repeat (8) tick();

    // Memory ready toggling.
    for (int k = 0; k < 12; k++) begin
      p_rdy = (k % 2 == 0) ? 100 : 0;
      tick();
    end
    p_rdy = 100;

    // Redirect with requests in flight (slow memory).
    max_lat = 3; p_ifr = 100;
    repeat (4) tick();
    force_redir = 1'b1; redir_tgt = 32'h0000_0103;
    tick();
    force_redir = 1'b0;
    chk("redir_pc", pc, 32'h0000_0100);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (if_valid) begin
        seen = 1'b1;
        chk("redir_first_pc", if_pc, 32'h0000_0100);
      end
    end
    if (!seen) chk("redir_timeout", 32'd0, 32'd1);

    // Redirect coinciding with a response and a pop at full speed.
    max_lat = 1;
    repeat (6) tick();
    force_redir = 1'b1; redir_tgt = 32'h0000_2000;
    tick();
    force_redir = 1'b0;
    chk("redir2_pc", pc, 32'h0000_2000);
    repeat (6) tick();

    // PC wrap at the top of the address space.
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      pc = 32'hFFFF_FFFC;
      tick();
      if (last_acc) begin
        seen = 1'b1;
        chk("wrap_pc", pc, 32'h0);
      end
    end
    if (!seen) chk("wrap_timeout", 32'd0, 32'd1);
    repeat (4) tick();

    // Random traffic.
    p_rdy = 70; p_ifr = 60; p_rsp = 70; p_redir = 5; max_lat = 4;
    repeat (2000) tick();

    // Reset in the middle of operation, then more random traffic.
    rst = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    repeat (500) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the RV32I datapath. Consumes the current program counter, issues word fetches to instruction memory through a valid/ready request and in-order response port, and buffers returned instructions with their PCs for decode. Computes the next-PC value fed back to the program counter register, which loads every cycle. Branch/jump redirects flush the fetch path.

## Interface
- DEPTH, 2: entries in instruction buffer and in-flight address queue (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- pc  in  32  current PC from program counter register
- pc_next  out  32  next PC, drives program counter register input
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_target  in  32  redirect destination; bits [1:0] ignored
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  32  fetch address, always {pc[31:2],2'b00}
- imem_rsp_valid  in  1  instruction returned (in order, ≥1 cycle after acceptance, never back-pressured)
- imem_rsp_data  in  32  instruction word
- if_valid  out  1  buffer head valid toward decode
- if_ready  in  1  decode accepts head
- if_instr  out  32  head instruction
- if_pc  out  32  PC of head instruction

## Operation
- State: out_cnt (accepted, not yet returned), drop_cnt (in-flight responses to discard), address queue (PCs of in-flight requests), instruction buffer (FIFO of {pc, instr}).
- pop = if_valid & if_ready. credit = (out_cnt + occupancy − pop) < DEPTH.
- imem_req_valid = rst & ~redirect_valid & credit. Accept = imem_req_valid & imem_req_ready; pushes pc into address queue, out_cnt+1.
- pc_next priority: redirect_valid → {redirect_target[31:2],2'b00}; else accept → pc + 4 (32-bit wrap, 0xFFFFFFFC → 0x00000000); else pc.
- Response: pops address queue, out_cnt−1. If drop_cnt>0, data discarded and drop_cnt−1; else {queued pc, imem_rsp_data} pushed to buffer.
- Redirect: buffer cleared at the edge; drop_cnt ← out_cnt after this cycle's response (response arriving in redirect cycle is itself discarded); no request issued; pop ignored (if_valid still shows old head but decode must treat it as flushed).
- New requests after redirect may issue while drop_cnt>0; their responses follow dropped ones in order.
- Push and pop in same cycle allowed at any occupancy; credit guarantees buffer never overflows.

## Timing
- Reset (rst=0 at edge): out_cnt, drop_cnt, occupancy ← 0; if_valid=0; imem_req_valid=0 during reset cycles; pc_next=pc while rst=0.
- if_instr/if_pc undefined while if_valid=0; held stable while if_valid & ~if_ready.
- Latency: request accepted cycle t, response t+1 → if_valid at t+2 (buffer registered, no bypass).
- Throughput: 1 instruction/cycle with 1-cycle memory and if_ready=1, DEPTH=2.
- Redirect in cycle t: PC register holds target at t+1; first request for target at t+1; first valid instruction earliest t+3.
- Reset mid-operation: all in-flight state discarded; responses for pre-reset requests must not arrive post-reset (memory reset concurrently).

## Test plan
- Reset, pc=0, 1-cycle memory, if_ready=1 → requests 0x0,0x4,0x8… back-to-back; if_pc 0x0 at cycle 3, one instruction per cycle afterward.
- if_ready=0 for 5 cycles → at most DEPTH entries buffered, imem_req_valid drops, pc_next=pc; release → in-order delivery, no loss or duplicate.
- imem_req_ready toggling 1/0 → pc_next advances only on accepted cycles; addresses strictly +4 with no gaps.
- Redirect to 0x103 with 2 requests in flight → both responses dropped, buffer flushed, next request addr 0x100, first if_pc 0x100.
- Redirect coinciding with response and pop → response discarded, no request that cycle, pc_next=target.
- pc=0xFFFFFFFC accepted → pc_next=0x00000000.
